rob_complete_arbiter: RTL and testbench

- Collects completion results from NUM_REQ functional units and schedules them onto the reorder buffer's three completion ports (en_complete_instr0/1/2, complete_indx*, complete_pc*, complete_val*).
- Each requester has a small skid FIFO with a valid/ready handshake.
- Grants up to three distinct requesters per cycle using round-robin priority.
- Sits between the execute-stage units and the reorder buffer.

---
 rtl/rob_arb_pkg.sv | 22 ++
 rtl/complete_skid_fifo.sv | 52 +++++
 rtl/rob_complete_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rob_complete_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_arb_pkg.sv
// Shared types and constants for the ROB completion arbiter.
package rob_arb_pkg;

  localparam int NUM_COMPLETE_PORTS = 3;

  localparam int DEF_ROB_SIZE  = 16;
  localparam int DEF_PC_SIZE   = 32;
  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_INDX_W    = $clog2(DEF_ROB_SIZE);

  // Default completion payload; the top re-declares it with its own widths.
  typedef struct packed {
    logic [DEF_INDX_W-1:0]    indx;
    logic [DEF_PC_SIZE-1:0]   pc;
    logic [DEF_WORD_SIZE-1:0] val;
  } completion_s;

  function automatic int rr_wrap(input int a, input int n);
    return a % n;
  endfunction

endpackage

// File: rtl/complete_skid_fifo.sv
// Per-requester skid FIFO holding completion entries; head is read combinationally
// so the arbiter can forward it on the same edge it pops.
module complete_skid_fifo
  import rob_arb_pkg::*;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type entry_t    = completion_s
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  entry_t                        push_data_i,
  input  logic                          pop_i,
  output entry_t                        head_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               do_push;
  logic               do_pop;

  // A full FIFO never accepts, even if it pops in the same cycle.
  assign do_push = push_i && (count_reg != CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop_i && (count_reg != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i && !flush_i) mem_reg[wr_ptr_reg] <= push_data_i;
  end

  assign head_o  = mem_reg[rd_ptr_reg];
  assign count_o = count_reg;

endmodule

// File: rtl/rob_complete_arbiter.sv
// Schedules completions from NUM_REQ units onto the ROB's three completion ports
// with round-robin priority. Define COMPLETE_ARB_STATS_EN to add stall_cnt_o.
module rob_complete_arbiter
  import rob_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_SIZE   = 16,
  parameter int PC_SIZE    = 32,
  parameter int WORD_SIZE  = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ*$clog2(ROB_SIZE)-1:0]  req_indx_i,
  input  logic [NUM_REQ*PC_SIZE-1:0]           req_pc_i,
  input  logic [NUM_REQ*WORD_SIZE-1:0]         req_val_i,
`ifdef COMPLETE_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]                stall_cnt_o,
`endif
  output logic                                 en_complete_instr0_o,
  output logic                                 en_complete_instr1_o,
  output logic                                 en_complete_instr2_o,
  output logic [$clog2(ROB_SIZE)-1:0]          complete_indx0_o,
  output logic [$clog2(ROB_SIZE)-1:0]          complete_indx1_o,
  output logic [$clog2(ROB_SIZE)-1:0]          complete_indx2_o,
  output logic [PC_SIZE-1:0]                   complete_pc0_o,
  output logic [PC_SIZE-1:0]                   complete_pc1_o,
  output logic [PC_SIZE-1:0]                   complete_pc2_o,
  output logic [WORD_SIZE-1:0]                 complete_val0_o,
  output logic [WORD_SIZE-1:0]                 complete_val1_o,
  output logic [WORD_SIZE-1:0]                 complete_val2_o
);

  localparam int INDX_W = $clog2(ROB_SIZE);
  localparam int RR_W   = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int NP     = NUM_COMPLETE_PORTS;

  typedef struct packed {
    logic [INDX_W-1:0]    indx;
    logic [PC_SIZE-1:0]   pc;
    logic [WORD_SIZE-1:0] val;
  } cmpl_t;

  cmpl_t              in_data   [NUM_REQ];
  cmpl_t              head_data [NUM_REQ];
  logic [CNT_W-1:0]   count     [NUM_REQ];
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] nonempty;

  logic [RR_W-1:0]    rr_ptr_reg;
  logic [RR_W-1:0]    rr_ptr_next;
  logic [NP-1:0]      slot_vld;
  logic [RR_W-1:0]    slot_req [NP];

  logic [NP-1:0]      slot_en_reg;
  cmpl_t              slot_data_reg [NP];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign in_data[gi] = '{indx: req_indx_i[gi*INDX_W +: INDX_W],
                             pc:   req_pc_i[gi*PC_SIZE +: PC_SIZE],
                             val:  req_val_i[gi*WORD_SIZE +: WORD_SIZE]};
      assign req_ready_o[gi] = (count[gi] < CNT_W'(FIFO_DEPTH)) && !rst_i && !flush_i;
      assign push[gi]        = req_valid_i[gi] && req_ready_o[gi];
      assign nonempty[gi]    = (count[gi] != '0);

      complete_skid_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (cmpl_t)
      ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push[gi]),
        .push_data_i (in_data[gi]),
        .pop_i       (pop[gi]),
        .head_o      (head_data[gi]),
        .count_o     (count[gi])
      );
    end
  endgenerate

  // Walk requesters from rr_ptr; the first NP non-empty ones fill slots in order.
  always_comb begin
    logic [1:0]      n_granted;
    logic [RR_W-1:0] idx;
    pop         = '0;
    slot_vld    = '0;
    rr_ptr_next = rr_ptr_reg;
    n_granted   = '0;
    idx         = '0;
    for (int k = 0; k < NP; k++) slot_req[k] = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = RR_W'(rr_wrap(int'(rr_ptr_reg) + i, NUM_REQ));
      if (nonempty[idx] && (n_granted != 2'(NP))) begin
        pop[idx]            = 1'b1;
        slot_vld[n_granted] = 1'b1;
        slot_req[n_granted] = idx;
        rr_ptr_next         = RR_W'(rr_wrap(int'(idx) + 1, NUM_REQ));
        n_granted           = n_granted + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg <= '0;
    end else if (!flush_i) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Empty slots keep their last payload; only the enable drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_en_reg <= '0;
      for (int k = 0; k < NP; k++) slot_data_reg[k] <= '0;
    end else if (flush_i) begin
      slot_en_reg <= '0;
    end else begin
      slot_en_reg <= slot_vld;
      for (int k = 0; k < NP; k++) begin
        if (slot_vld[k]) slot_data_reg[k] <= head_data[slot_req[k]];
      end
    end
  end

  assign en_complete_instr0_o = slot_en_reg[0];
  assign en_complete_instr1_o = slot_en_reg[1];
  assign en_complete_instr2_o = slot_en_reg[2];
  assign complete_indx0_o     = slot_data_reg[0].indx;
  assign complete_indx1_o     = slot_data_reg[1].indx;
  assign complete_indx2_o     = slot_data_reg[2].indx;
  assign complete_pc0_o       = slot_data_reg[0].pc;
  assign complete_pc1_o       = slot_data_reg[1].pc;
  assign complete_pc2_o       = slot_data_reg[2].pc;
  assign complete_val0_o      = slot_data_reg[0].val;
  assign complete_val1_o      = slot_data_reg[1].val;
  assign complete_val2_o      = slot_data_reg[2].val;

`ifdef COMPLETE_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [31:0] stall_cnt_reg;
      // Saturating; flush leaves the history intact.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          stall_cnt_reg <= '0;
        end else if (req_valid_i[gi] && !req_ready_o[gi] && (stall_cnt_reg != '1)) begin
          stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
      end
      assign stall_cnt_o[gi*32 +: 32] = stall_cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Self-checking bench for rob_complete_arbiter: vector table plus scoreboarded
// streaming sequences for backpressure, fairness, flush and reset.
module tb_rob_complete_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [NR-1:0] valid;
  logic [NR-1:0] ready;
  logic [15:0]   indx_bus;
  logic [127:0]  pc_bus;
  logic [127:0]  val_bus;
  logic          en0, en1, en2;
  logic [3:0]    ix0, ix1, ix2;
  logic [31:0]   pc0, pc1, pc2;
  logic [31:0]   v0, v1, v2;
`ifdef COMPLETE_ARB_STATS_EN
  logic [NR*32-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  rob_complete_arbiter dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .req_valid_i          (valid),
    .req_ready_o          (ready),
    .req_indx_i           (indx_bus),
    .req_pc_i             (pc_bus),
    .req_val_i            (val_bus),
`ifdef COMPLETE_ARB_STATS_EN
    .stall_cnt_o          (stall_cnt),
`endif
    .en_complete_instr0_o (en0),
    .en_complete_instr1_o (en1),
    .en_complete_instr2_o (en2),
    .complete_indx0_o     (ix0),
    .complete_indx1_o     (ix1),
    .complete_indx2_o     (ix2),
    .complete_pc0_o       (pc0),
    .complete_pc1_o       (pc1),
    .complete_pc2_o       (pc2),
    .complete_val0_o      (v0),
    .complete_val1_o      (v1),
    .complete_val2_o      (v2)
  );

  typedef struct {
    int          req;
    logic [67:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] exp_en;
    int         s0;
    int         s1;
    int         s2;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   seq_n = 0;
  int   stall_seen[NR];
  int   grant_cnt[NR];
  int   wait_cnt[NR];
  int   max_wait = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] cur_en();
    return {en2, en1, en0};
  endfunction

  function automatic logic [67:0] slot_data(input int k);
    case (k)
      0:       return {ix0, pc0, v0};
      1:       return {ix1, pc1, v1};
      default: return {ix2, pc2, v2};
    endcase
  endfunction

  task automatic set_req(input int r, input logic [3:0] ix, input logic [31:0] pc, input logic [31:0] v);
    indx_bus[r*4 +: 4]  = ix;
    pc_bus[r*32 +: 32]  = pc;
    val_bus[r*32 +: 32] = v;
    valid[r]            = 1'b1;
  endtask

  // Requester id lives in val[31:28] so outputs can be routed back to the scoreboard.
  task automatic auto_req(input int r);
    seq_n++;
    set_req(r, 4'(seq_n), 32'(r * 4096 + seq_n * 4), {4'(r), 12'h000, 16'(seq_n)});
  endtask

  task automatic refresh(input logic [3:0] mask);
    for (int r = 0; r < NR; r++) begin
      if (mask[r]) auto_req(r);
      else         valid[r] = 1'b0;
    end
  endtask

  task automatic tick();
    logic [2:0]  en;
    logic [67:0] d;
    logic [3:0]  gmask;
    int          r;
    bit          found;
    bit          rs;
    bit          fl;
    @(negedge clk);
    rs = rst;
    fl = flush;
    for (int i = 0; i < NR; i++) begin
      if (rs) stall_seen[i] = 0;
      else if (valid[i] && !ready[i]) stall_seen[i]++;
    end
    if (rs || fl) begin
      sb.delete();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (valid[i] && ready[i])
          sb.push_back('{req: i, data: {indx_bus[i*4 +: 4], pc_bus[i*32 +: 32], val_bus[i*32 +: 32]}});
      end
    end
    @(posedge clk);
    #1;
    en = cur_en();
    if (rs || fl) check("en_after_clear", en, 0);
    check("slot_no_gap", (en == 3'b000 || en == 3'b001 || en == 3'b011 || en == 3'b111), 1);
    gmask = '0;
    for (int k = 0; k < 3; k++) begin
      if (en[k]) begin
        d     = slot_data(k);
        r     = int'(d[31:28]);
        found = 1'b0;
        for (int i = 0; i < sb.size(); i++) begin
          if (!found && sb[i].req == r) begin
            check("slot_data", d, sb[i].data);
            sb.delete(i);
            found = 1'b1;
          end
        end
        if (!found) begin
          checks++;
          errors++;
          $display("FAIL orphan_output slot=%0d actual=%h required=pending_entry", k, d);
        end else begin
          check("dup_grant", gmask[r], 0);
          gmask[r] = 1'b1;
          grant_cnt[r]++;
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (gmask[i]) wait_cnt[i] = 0;
      else begin
        wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = '0;
    tick();
    rst   = 1'b0;
  endtask

  task automatic clear_stats();
    max_wait = 0;
    for (int i = 0; i < NR; i++) begin
      grant_cnt[i] = 0;
      wait_cnt[i]  = 0;
    end
  endtask

  initial begin
    logic [67:0] d;
    int          exp_s[3];

    rst      = 1'b1;
    flush    = 1'b0;
    valid    = '0;
    indx_bus = '0;
    pc_bus   = '0;
    val_bus  = '0;
    for (int i = 0; i < NR; i++) stall_seen[i] = 0;
    clear_stats();

    vecs[0] = '{mask: 4'b0001, exp_en: 3'b001, s0: 0, s1: 0, s2: 0};
    vecs[1] = '{mask: 4'b0010, exp_en: 3'b001, s0: 1, s1: 0, s2: 0};
    vecs[2] = '{mask: 4'b1010, exp_en: 3'b011, s0: 1, s1: 3, s2: 0};
    vecs[3] = '{mask: 4'b1111, exp_en: 3'b111, s0: 0, s1: 1, s2: 2};
    vecs[4] = '{mask: 4'b1110, exp_en: 3'b111, s0: 1, s1: 2, s2: 3};
    vecs[5] = '{mask: 4'b1101, exp_en: 3'b111, s0: 0, s1: 2, s2: 3};
    vecs[6] = '{mask: 4'b0000, exp_en: 3'b000, s0: 0, s1: 0, s2: 0};
    vecs[7] = '{mask: 4'b1000, exp_en: 3'b001, s0: 3, s1: 0, s2: 0};

    // Reset state, including ready held low while reset is high.
    #2;
    valid = 4'hF;
    #1;
    check("ready_in_reset", ready, 4'h0);
    valid = '0;
    tick();
    rst = 1'b0;
    check("reset_en", cur_en(), 0);
    check("reset_data", {slot_data(0), slot_data(1), slot_data(2)}, 0);
    #1;
    check("ready_after_reset", ready, 4'hF);

    // Single push: visible one edge after acceptance, not on the accepting edge.
    set_req(0, 4'd5, 32'h40, 32'hAB);
    tick();
    check("single_lat_early", cur_en(), 0);
    valid = '0;
    tick();
    check("single_en", cur_en(), 3'b001);
    check("single_indx", ix0, 4'd5);
    check("single_pc", pc0, 32'h40);
    check("single_val", v0, 32'hAB);

    // Arbitration table, each vector from a fresh reset (rr_ptr=0).
    for (int v = 0; v < 8; v++) begin
      do_reset();
      refresh(vecs[v].mask);
      tick();
      valid = '0;
      tick();
      check("vec_en", cur_en(), vecs[v].exp_en);
      exp_s[0] = vecs[v].s0;
      exp_s[1] = vecs[v].s1;
      exp_s[2] = vecs[v].s2;
      for (int k = 0; k < 3; k++) begin
        if (vecs[v].exp_en[k]) begin
          d = slot_data(k);
          check("vec_slot_req", d[31:28], exp_s[k]);
        end
      end
    end

    // Four simultaneous pushes: req3 follows on slot 0, then rr_ptr is back at 0.
    do_reset();
    refresh(4'b1111);
    tick();
    valid = '0;
    tick();
    tick();
    check("four_tail_en", cur_en(), 3'b001);
    d = slot_data(0);
    check("four_tail_req", d[31:28], 3);
    refresh(4'b1001);
    tick();
    valid = '0;
    tick();
    check("rr_wrap_en", cur_en(), 3'b011);
    d = slot_data(0);
    check("rr_wrap_slot0", d[31:28], 0);
    d = slot_data(1);
    check("rr_wrap_slot1", d[31:28], 3);

    // Backpressure: req2 valid 5 cycles against saturating traffic.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      refresh(4'b1111);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      refresh(4'b1011);
      tick();
    end
    check("req2_backpressure", stall_seen[2] > 0, 1);
`ifdef COMPLETE_ARB_STATS_EN
    for (int i = 0; i < NR; i++) check("stall_cnt", stall_cnt[i*32 +: 32], stall_seen[i]);
`endif
    valid = '0;
    for (int c = 0; c < 4; c++) tick();
    check("bp_drained", sb.size(), 0);

    // Fairness over 8 saturated output cycles.
    do_reset();
    refresh(4'b1111);
    tick();
    clear_stats();
    for (int c = 0; c < 8; c++) begin
      refresh(4'b1111);
      tick();
    end
    for (int i = 0; i < NR; i++) check("fair_grants", grant_cnt[i], 6);
    check("fair_max_wait", max_wait <= 2, 1);
    valid = '0;
    for (int c = 0; c < 4; c++) tick();
    check("fair_drained", sb.size(), 0);

    // Flush with 5 buffered entries.
    do_reset();
    refresh(4'b1111);
    tick();
    refresh(4'b1111);
    tick();
    flush = 1'b1;
    refresh(4'b1111);
    #2;
    check("ready_in_flush", ready, 4'h0);
    tick();
    flush = 1'b0;
    valid = '0;
    #2;
    check("ready_after_flush", ready, 4'hF);
    tick();
    check("flush_idle_en", cur_en(), 0);
    refresh(4'b0010);
    tick();
    valid = '0;
    tick();
    check("post_flush_en", cur_en(), 3'b001);
    d = slot_data(0);
    check("post_flush_req", d[31:28], 1);

    // Reset in the middle of a stream.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      refresh(4'b1111);
      tick();
    end
    check("stream_active", en0, 1);
    rst = 1'b1;
    refresh(4'b1111);
    #2;
    check("ready_mid_reset", ready, 4'h0);
    tick();
    check("mid_reset_data", {slot_data(0), slot_data(1), slot_data(2)}, 0);
    rst   = 1'b0;
    valid = '0;
    tick();
    check("mid_reset_empty", cur_en(), 0);
    refresh(4'b1001);
    tick();
    valid = '0;
    tick();
    d = slot_data(0);
    check("mid_reset_rr", d[31:28], 0);
    tick();
    check("final_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
